// File: rtl/foo_stream_shim_if.sv
// foo_stream_shim_if: operand input stream and result output stream (valid/ready)
interface foo_stream_shim_if;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/foo_stream_shim.sv
// foo_stream_shim: FIFO-buffered operand feed to foo.a with settle window and foo.x result capture
module foo_stream_shim #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  foo_stream_shim_if.slave       s,
  output logic [31:0]            foo_a,
  input  logic [31:0]            foo_x,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;
  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    settle_q, settle_d;
  logic [31:0]   foo_a_q, out_data_q;
  logic          out_valid_q, out_valid_d, push, pop, cap;
  assign s.in_ready  = count_q < FULL;
  assign push        = s.in_valid && s.in_ready;
  assign count_d     = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign foo_a       = foo_a_q;
  assign s.out_data  = out_data_q;
  assign s.out_valid = out_valid_q;
  assign busy        = state_q != S_IDLE;
  assign count       = count_q;
  // pop decisions use registered count only, so a same-cycle push never falls through
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    cap         = 1'b0;
    case (state_q)
      S_IDLE: begin
        pop      = count_q != '0;
        settle_d = pop ? SETTLE_LD : settle_q;
        state_d  = pop ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: begin
        cap         = settle_q == 4'd0;
        settle_d    = cap ? settle_q : settle_q - 4'd1;
        out_valid_d = cap ? 1'b1 : out_valid_q;
        state_d     = cap ? S_HOLD : S_SETTLE;
      end
      S_HOLD: begin
        pop         = s.out_ready && count_q != '0;
        settle_d    = pop ? SETTLE_LD : settle_q;
        out_valid_d = s.out_ready ? 1'b0 : out_valid_q;
        state_d     = pop ? S_SETTLE : (s.out_ready ? S_IDLE : S_HOLD);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      settle_q    <= '0;
      foo_a_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      settle_q    <= settle_d;
      out_valid_q <= out_valid_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (pop) foo_a_q <= mem_q[rd_q];
      if (cap) out_data_q <= foo_x;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s.in_data;
  end
endmodule

// File: tb/tb_foo_stream_shim.sv
// tb_foo_stream_shim: scoreboard bench for foo_stream_shim with an inverting foo model
module tb_foo_stream_shim;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] foo_a, foo_x;
  logic        busy;
  logic [2:0]  count;
  logic        acc;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];
  foo_stream_shim_if bus();
  foo_stream_shim #(.DEPTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .s(bus), .foo_a(foo_a), .foo_x(foo_x), .busy(busy), .count(count)
  );
  assign foo_x = foo_a ^ 32'hFFFF_FFFF;
  always #5 clk = ~clk;

  // drive at negedge; handshakes seen here complete at the following posedge
  task automatic step(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    cyc++;
    acc = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(d ^ 32'hFFFF_FFFF);
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 100 && got_q.size() < n; k++) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0;
    bus.in_data = 32'h0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (foo_a !== 32'h0) begin errors++; $display("FAIL reset_foo_a got %h exp 00000000", foo_a); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 00000000", bus.out_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [31:0] g, e;
    exp_q.delete(); got_q.delete();
    step(1'b1, 32'h0000_1234, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count_e0 got %0d exp 1", count); end
    step(1'b0, 32'h0, 1'b1);
    checks++; if (foo_a !== 32'h0000_1234) begin errors++; $display("FAIL single_foo_a_e1 got %h exp 00001234", foo_a); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_e1 got %b exp 0", bus.out_valid); end
    step(1'b0, 32'h0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_e2 got %b exp 0", bus.out_valid); end
    step(1'b0, 32'h0, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_ov_e3 got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'hFFFF_EDCB) begin errors++; $display("FAIL single_data_e3 got %h exp ffffedcb", bus.out_data); end
    step(1'b0, 32'h0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_e4 got %b exp 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_e4 got %b exp 0", busy); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_n got %0d exp 1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL single_sb got %h exp %h", g, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] g, e;
    int bad = 0;
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    for (int i = 1; i <= 3; i++) step(1'b1, 32'(i), 1'b1);
    for (int k = 0; k < 40 && got_q.size() < 3; k++) begin
      step(1'b0, 32'h0, 1'b1);
      if (got_q.size() < 3 && busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_busy got %0d idle cycles exp 0", bad); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL b2b_n got %0d exp 3", got_q.size()); end
    if (got_cyc.size() == 3) begin
      checks++; if (got_cyc[1] - got_cyc[0] != 3) begin errors++; $display("FAIL b2b_gap0 got %0d exp 3", got_cyc[1] - got_cyc[0]); end
      checks++; if (got_cyc[2] - got_cyc[1] != 3) begin errors++; $display("FAIL b2b_gap1 got %0d exp 3", got_cyc[2] - got_cyc[1]); end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_sb got %h exp %h", g, e); end
    end
    step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_full_fifo;
    logic [31:0] g, e;
    int n = 0;
    int stall = 0;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h100 + 32'(i), 1'b0);
      n += int'(acc);
    end
    checks++; if (n != 5) begin errors++; $display("FAIL full_accepted got %0d exp 5", n); end
    step(1'b1, 32'h105, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", bus.in_ready); end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h105, 1'b0);
      stall += int'(acc);
    end
    checks++; if (stall != 0) begin errors++; $display("FAIL full_stall got %0d accepts exp 0", stall); end
    step(1'b1, 32'h105, 1'b1);
    checks++; if (acc !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_accept got %b exp 0", acc); end
    step(1'b1, 32'h105, 1'b0);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", acc); end
    drain(6);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL full_n got %0d exp 6", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL full_sb got %h exp %h", g, e); end
    end
    step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_backpressure;
    logic [31:0] g, e, od, fa;
    int drift = 0;
    exp_q.delete(); got_q.delete();
    step(1'b1, 32'hA5A5_0000, 1'b0);
    step(1'b1, 32'h5A5A_FFFF, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (bus.out_valid) break;
      step(1'b0, 32'h0, 1'b0);
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", bus.out_valid); end
    od = bus.out_data;
    fa = foo_a;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 32'h0, 1'b0);
      if (bus.out_data !== od || foo_a !== fa || bus.out_valid !== 1'b1) drift++;
    end
    checks++; if (drift != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", drift); end
    checks++; if (fa !== 32'hA5A5_0000) begin errors++; $display("FAIL bp_foo_a got %h exp a5a50000", fa); end
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    checks++; if (foo_a !== 32'h5A5A_FFFF) begin errors++; $display("FAIL bp_reload got %h exp 5a5affff", foo_a); end
    repeat (5) step(1'b0, 32'h0, 1'b0);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL bp_one_transfer got %0d exp 1", got_q.size()); end
    drain(2);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL bp_sb got %h exp %h", g, e); end
    end
    step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid_settle;
    logic [31:0] g, e;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 32'hC0 + 32'(i), 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (bus.out_valid) break;
      step(1'b0, 32'h0, 1'b0);
    end
    step(1'b0, 32'h0, 1'b1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rst_pre_n got %0d exp 1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rst_pre_sb got %h exp %h", g, e); end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ov got %b exp 0", bus.out_valid); end
    checks++; if (foo_a !== 32'h0) begin errors++; $display("FAIL rst_mid_foo_a got %h exp 00000000", foo_a); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_mid_count got %0d exp 0", count); end
    checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_ready got %b%b exp 01", busy, bus.in_ready); end
    exp_q.delete(); got_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) step(1'b0, 32'h0, 1'b1);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_stale got %0d results exp 0", got_q.size()); end
    step(1'b1, 32'h0, 1'b1);
    drain(1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rst_post_n got %0d exp 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_post_data got %h exp ffffffff", got_q[0]); end
    end
    exp_q.delete(); got_q.delete();
    step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_pointer_wrap;
    logic [31:0] g, e;
    int nxt = 0;
    exp_q.delete(); got_q.delete();
    for (int k = 0; k < 400 && got_q.size() < 10; k++) begin
      step(nxt < 10, 32'(nxt), 1'($urandom_range(0, 1)));
      if (acc) nxt++;
    end
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL wrap_n got %0d exp 10", got_q.size()); end
    checks++; if (exp_q.size() != got_q.size()) begin errors++; $display("FAIL wrap_sizes got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL wrap_sb got %h exp %h", g, e); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_full_fifo;
    test_backpressure;
    test_reset_mid_settle;
    test_pointer_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/foo_stream_shim.md
# foo_stream_shim

Streaming front-end for the `foo` black-box wrapper. It accepts 32-bit operands over a valid/ready input stream and buffers them in a small FIFO. Each operand is presented to `foo`'s `a` input and held stable for a fixed settle window, then `foo`'s `x` is captured and returned over a valid/ready output stream. It sits directly upstream of `foo` (drives `a`) and directly downstream of it (consumes `x`), sharing `foo`'s `clk`.

## Interface
- `DEPTH`, 4: input FIFO entries; power of two, ≥ 2.
- `SETTLE`, 2: cycles `foo_a` is held before `foo_x` is sampled; range 1..15.
- `clk` in 1: single clock; also drives `foo.clk`.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: FIFO can accept.
- `in_data` in 32: operand.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_data` out 32: captured `foo.x`.
- `foo_a` out 32: registered drive to `foo.a`.
- `foo_x` in 32: `foo.x`, treated as combinational from `foo_a`.
- `busy` out 1: state ≠ IDLE.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **FIFO:**
  - Push on `in_valid && in_ready`. `in_ready = (count < DEPTH)`, purely from registered `count`.
  - No fall-through: a pushed entry is poppable at the earliest one edge after the push.
  - Push and pop in the same cycle leave `count` unchanged.
  - Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, SETTLE, HOLD.
- **IDLE:**
  - If `count != 0`: pop the head into `foo_a`, load `settle_cnt = SETTLE-1`, go to SETTLE.
  - Otherwise stay. `foo_a` keeps its last value, so `foo` is never re-driven spuriously.
- **SETTLE:**
  - If `settle_cnt != 0`: decrement it.
  - Else: capture `out_data <= foo_x`, set `out_valid <= 1`, go to HOLD.
- **HOLD:**
  - `out_valid` and `out_data` are held stable until `out_ready`.
  - On the handshake, if `count != 0`, pop, reload `foo_a` and `settle_cnt`, and go to SETTLE in the same edge (back-to-back). `out_valid` falls.
  - On the handshake with an empty FIFO: go to IDLE, `out_valid` falls.
  - Without the handshake: stay.
- `foo_a` changes only on a pop edge.
- `out_data` changes only on the SETTLE→HOLD edge.
- Results are delivered in operand acceptance order.
- No arithmetic on data. `settle_cnt` is 4 bits; `count` saturates logically at DEPTH because `in_ready` is low when full.

## Timing
- **Reset** (async assert, synchronous-release usage assumed by system):
  - State IDLE.
  - `foo_a = 0`, `out_data = 0`, `out_valid = 0`, `count = 0`, `in_ready = 1`, `busy = 0`.
  - FIFO pointers 0, `settle_cnt = 0`.
- **Latency:**
  - Operand accepted at edge E, FIFO previously empty, state IDLE: pop at E+1 (`foo_a` valid after E+1).
  - `out_valid` rises after edge E+1+SETTLE.
- **Throughput:** with `out_ready` held high, one result per SETTLE+1 cycles.
- **Full FIFO:**
  - `in_ready = 0`; the input is stalled regardless of a pop in the same cycle.
  - `in_ready` returns to 1 one cycle after the pop.
- **Empty FIFO:** no pop; FSM rests in IDLE or HOLD.
- **Output backpressure:** indefinite `out_ready = 0` holds HOLD. The FIFO keeps accepting until full.
- **Reset mid-operation:**
  - All in-flight and buffered operands are discarded and `out_valid` drops immediately.
  - `foo_a` returns to 0. `foo` is not reset by this block.

## Test plan
Bench model for `foo`: `foo_x = foo_a ^ 32'hFFFF_FFFF` (combinational).
- **Single operand:** SETTLE=2; push 32'h0000_1234 at edge 0 with `out_ready = 1` → `foo_a = 32'h1234` after edge 1; `out_valid = 1` with `out_data = 32'hFFFF_EDCB` after edge 3; `out_valid` drops after edge 4.
- **Back-to-back:** push 1, 2, 3 on consecutive edges with `out_ready = 1` → outputs FFFF_FFFE, FFFF_FFFD, FFFF_FFFC in order, one every 3 cycles; `busy` stays 1 throughout.
- **Full FIFO:** DEPTH=4, `out_ready = 0`; push 6 operands →
  - The first is popped into flight, so 5 are accepted.
  - `count` reaches 4 and `in_ready = 0`.
  - The 6th stalls until `out_ready` pulses.
  - After the pulse, `in_ready` rises one cycle later.
- **Backpressure stability:** hold `out_ready = 0` for 10 cycles after `out_valid` → `out_data` and `foo_a` remain constant; one `out_ready` pulse completes exactly one transfer.
- **Reset mid-SETTLE:** assert `rst` between edges while `settle_cnt = 1` with 2 entries queued → outputs take reset values immediately; after release, no stale result appears; a new push of 32'h0 yields 32'hFFFF_FFFF.
- **Pointer wrap:** stream 10 operands (0..9) through DEPTH=4 with random `out_ready` → the 10 results arrive in order with no loss or duplication.
